// File: rtl/dbus_bridge_pkg.sv
// Shared constants and address decode for the data-bus bridge.
// The I/O page sits at 0xFxxx; everything else belongs to the data RAM.
package dbus_bridge_pkg;

  localparam logic [3:0]  IO_PAGE   = 4'hF;
  localparam logic [15:0] ADDR_TUBE = 16'hF000;
  localparam logic [15:0] ADDR_LED  = 16'hF060;
  localparam logic [15:0] ADDR_SW   = 16'hF070;
  localparam int          IO_W      = 24;

  typedef enum logic [2:0] {
    SRC_DRAM,
    SRC_TUBE,
    SRC_LED,
    SRC_SW,
    SRC_NONE
  } io_src_e;

  function automatic io_src_e decode_src(input logic [15:0] addr);
    if (addr[15:12] != IO_PAGE) return SRC_DRAM;
    case (addr)
      ADDR_TUBE: return SRC_TUBE;
      ADDR_LED:  return SRC_LED;
      ADDR_SW:   return SRC_SW;
      default:   return SRC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dbus_bridge_seg7_decode.sv
// Hex nibble to active-low seven-segment glyph (bit order g..a).
module seg7_decode (
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  always_comb begin
    case (nibble)
      4'h0: segs = 7'h40;
      4'h1: segs = 7'h79;
      4'h2: segs = 7'h24;
      4'h3: segs = 7'h30;
      4'h4: segs = 7'h19;
      4'h5: segs = 7'h12;
      4'h6: segs = 7'h02;
      4'h7: segs = 7'h78;
      4'h8: segs = 7'h00;
      4'h9: segs = 7'h10;
      4'hA: segs = 7'h08;
      4'hB: segs = 7'h03;
      4'hC: segs = 7'h46;
      4'hD: segs = 7'h21;
      4'hE: segs = 7'h06;
      default: segs = 7'h0E;
    endcase
  end

endmodule

// File: rtl/dbus_bridge.sv
// Data-bus responder: routes core loads/stores to the data RAM or to the
// memory-mapped LED, switch and seven-segment tube registers.
module dbus_bridge
  import dbus_bridge_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        x_addr,
  input  logic               x_dram_wen,
  input  logic [31:0]        x_dram_wdata,
  output logic [31:0]        dram_rdata,
  output logic               ram_we,
  output logic [11:0]        ram_a,
  output logic [31:0]        ram_d,
  input  logic [31:0]        ram_spo,
  input  logic [IO_W-1:0]    sw,
  output logic [IO_W-1:0]    led,
  output logic [7:0]         dig_en,
  output logic [7:0]         seg
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  io_src_e           src;
  logic              io_sel;
  logic [31:0]       tube;
  logic [IO_W-1:0]   sw_meta;
  logic [IO_W-1:0]   sw_sync;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        idx;
  logic [6:0]        glyph;

  assign src    = decode_src(x_addr);
  assign io_sel = (x_addr[15:12] == IO_PAGE);

  assign ram_a  = x_addr[13:2];
  assign ram_d  = x_dram_wdata;
  assign ram_we = x_dram_wen & ~io_sel;

  // NOTE: every output of a combinational mux gets a default first so no latch is inferred.
  always_comb begin
    dram_rdata = 32'h0;
    case (src)
      SRC_DRAM: dram_rdata = ram_spo;
      SRC_TUBE: dram_rdata = tube;
      SRC_LED:  dram_rdata = {8'h0, led};
      SRC_SW:   dram_rdata = {8'h0, sw_sync};
      default:  dram_rdata = 32'h0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tube <= 32'h0;
      led  <= '0;
    end else if (x_dram_wen) begin
      if (src == SRC_TUBE) tube <= x_dram_wdata;
      if (src == SRC_LED)  led  <= x_dram_wdata[IO_W-1:0];
    end
  end

  // sw is asynchronous to clk; only the second stage is ever read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  seg7_decode u_seg7 (
    .nibble (tube[{idx, 2'b00} +: 4]),
    .segs   (glyph)
  );

  assign dig_en = ~(8'b1 << idx);
  assign seg    = {1'b1, glyph};

endmodule

// File: doc/dbus_bridge.md
# dbus_bridge

Data-bus responder behind the pipelined core's data-memory port: decodes the 16-bit data address, forwards DRAM accesses to the data RAM, and services memory-mapped I/O (LEDs, switches, 8-digit seven-segment tube). Sits between the core's MEM stage (`x_addr`, `x_dram_wen`, `x_dram_wdata`, `dram_rdata`) and the board top level. Read data is combinational because the core samples it in the same cycle. All I/O state, the switch synchroniser and the display scanner are sequential.

## Interface
- `SCAN_DIV`, 50000: clk cycles per displayed digit; legal range ≥ 2.
- `clk` in 1: single clock; all flops on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `x_addr` in 16: byte address from core.
- `x_dram_wen` in 1: write strobe from core.
- `x_dram_wdata` in 32: store data from core.
- `dram_rdata` out 32: load data to core, combinational.
- `ram_we` out 1: data-RAM write enable.
- `ram_a` out 12: data-RAM word address.
- `ram_d` out 32: data-RAM write data.
- `ram_spo` in 32: data-RAM asynchronous read data.
- `sw` in 24: raw board switches, asynchronous to `clk`.
- `led` out 24: LED drive, active-high.
- `dig_en` out 8: digit enables, active-low, one-hot-zero.
- `seg` out 8: segments, active-low, `seg[7]`=DP, `seg[6:0]`=g..a.

## Operation
- Decode: `io_sel = (x_addr[15:12] == 4'hF)`. Otherwise the access is DRAM.
- DRAM path:
  - `ram_a = x_addr[13:2]`, `ram_d = x_dram_wdata`, `ram_we = x_dram_wen & ~io_sel`.
  - Read returns `ram_spo`.
  - Address bits [1:0] are ignored (word access only).
- I/O map:
  - 0xF000 tube reg (R/W, 32b).
  - 0xF060 LED reg (R/W, low 24b; upper write bits dropped).
  - 0xF070 switches (RO, reads `{8'h0, sw_sync}`).
  - Other 0xFxxx: reads 0, writes ignored.
  - `ram_we` is 0 for every I/O access.
- Writes: a register updates on the rising edge where `x_dram_wen & io_sel` and the address matches.
- Reads: `dram_rdata` is a pure mux of the selected source in the same cycle. A read of a register on the edge it is written returns the old value before the edge and the new value after it.
- Switch sync: two-flop synchroniser; `sw_sync` is the second stage.
- Scanner:
  - `cnt` counts 0..SCAN_DIV-1. On reaching SCAN_DIV-1 it wraps to 0 and `idx` (3b) increments, wrapping 7→0.
  - `dig_en = ~(8'b1 << idx)`.
  - `seg = {1'b1, hex7(tube[4*idx +: 4])}`; DP is always off.
  - hex7 uses the standard 0-F glyphs, active-low: 0→7'h40, 1→7'h79, 8→7'h00, F→7'h0E.
- `led` = LED register directly.

## Timing
- Reset values: tube 0, LED 0, sw sync flops 0, `cnt` 0, `idx` 0. Hence `led`=0, `dig_en`=8'hFE, `seg`=8'hC0.
- Reset asserted mid-operation clears all of the above immediately, without waiting for a clock edge.
- DRAM writes complete in the RAM on the same edge as the core's MEM stage; there are no wait states and no stalls.
- Switch change is visible on reads 2 edges after it is stable at `sw`.
- Tube write on edge N: `seg` reflects the new nibble from edge N onward.
- Tube write coinciding with an `idx` advance: the new digit shows the new value.
- Digit period is SCAN_DIV cycles; full refresh is 8×SCAN_DIV.
- `dig_en`/`seg` change only after a clock edge (driven from `idx`/tube flops plus decode), never directly from bus inputs.

## Structure
- Shared package: I/O base constants (IO_PAGE 4'hF, ADDR_TUBE 16'hF000, ADDR_LED 16'hF060, ADDR_SW 16'hF070) and the LED/switch width 24.
- Sub-module `seg7_decode`: 4-bit nibble in, 7-bit active-low segments out, combinational; instantiated once.
- Scanner counter, register file and synchroniser live in the top module.

## Test plan
- Reset, SCAN_DIV=4: hold `rst`=0 → `led`=0, `dig_en`=8'hFE, `seg`=8'hC0. Release → `dig_en` becomes 8'hFD after 4 edges and returns to 8'hFE after 32.
- DRAM: write 0x12345678 at `x_addr`=0x0010 → `ram_we`=1, `ram_a`=12'h004. Read 0x0010 with `ram_spo`=0xCAFEF00D → `dram_rdata`=0xCAFEF00D.
- LED: write 0xFFABCDEF at 0xF060 → `ram_we`=0, `led`=24'hABCDEF after edge, read 0xF060 returns 0x00ABCDEF.
- Switches: set `sw`=24'h00A5A5 → read 0xF070 returns 0 for the first edge, 0x0000A5A5 from the second edge onward.
- Tube, SCAN_DIV=2: write 0x0000F081 at 0xF000 → across idx 0..3, `seg` = 8'hF9, 8'h80, 8'hC0, 8'h8E with `dig_en` = FE, FD, FB, F7.
- Unmapped I/O: write at 0xF100 changes nothing and asserts no `ram_we`; read returns 0. Reset asserted mid-scan forces `dig_en`=8'hFE immediately.
